// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade player-control conditioner:
// joystick bit positions and coin FSM states.
package arcade_input_pkg;

  localparam int JOY_R       = 0;
  localparam int JOY_L       = 1;
  localparam int JOY_D       = 2;
  localparam int JOY_U       = 3;
  localparam int JOY_FIRE    = 4;
  localparam int JOY_BARRIER = 5;
  localparam int JOY_START1  = 6;
  localparam int JOY_START2  = 7;
  localparam int JOY_COIN    = 8;
  localparam int JOY_USED    = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_t;

endpackage

// File: rtl/input_debounce.sv
// One-bit input conditioner: two-flop synchroniser followed by a
// stable-count debouncer that commits only after DEB_CYCLES agreeing samples.
module input_debounce #(
  parameter int DEB_CYCLES = 11000,
  parameter int CNT_W      = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchroniser into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  // Any sample that agrees with the held value restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else if (sync_r == dout) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      dout  <= sync_r;
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/arcade_input_cond.sv
// Conditions the merged player-control word for the Phoenix/Pleiads core:
// debounce, left/right conflict cancel, one shaped coin pulse per insertion.
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int DEB_CYCLES = 11000,
  parameter int COIN_PULSE = 110000,
  parameter int COIN_GAP   = 110000,
  parameter int CNT_W      = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy_in,
  output logic        btn_right,
  output logic        btn_left,
  output logic        btn_fire,
  output logic        btn_barrier,
  output logic [1:0]  btn_player_start,
  output logic        btn_coin,
  output logic [7:0]  coin_count
);

  localparam logic [CNT_W-1:0] T_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_PULSE_LAST = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] T_GAP_LAST   = CNT_W'(COIN_GAP - 1);

  logic [JOY_USED-1:0] deb_s;
  coin_state_t         state_r, state_nxt_s;
  logic [CNT_W-1:0]    t_r, t_nxt_s;
  logic                coin_nxt_s;
  logic [7:0]          count_nxt_s;
  logic                unused_s;

  assign unused_s = ^{joy_in[15:9], deb_s[JOY_D], deb_s[JOY_U]};

  for (genvar i = 0; i < JOY_USED; i++) begin : g_deb
    input_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (joy_in[i]),
      .dout (deb_s[i])
    );
  end

  // Button output register; opposing directions cancel each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_right        <= 1'b0;
      btn_left         <= 1'b0;
      btn_fire         <= 1'b0;
      btn_barrier      <= 1'b0;
      btn_player_start <= 2'b00;
    end else begin
      btn_right        <= deb_s[JOY_R] & ~deb_s[JOY_L];
      btn_left         <= deb_s[JOY_L] & ~deb_s[JOY_R];
      btn_fire         <= deb_s[JOY_FIRE];
      btn_barrier      <= deb_s[JOY_BARRIER];
      btn_player_start <= {deb_s[JOY_START2], deb_s[JOY_START1]};
    end
  end

  // Coin FSM state, shared timer and registered coin outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      t_r        <= T_ZERO;
      btn_coin   <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      t_r        <= t_nxt_s;
      btn_coin   <= coin_nxt_s;
      coin_count <= count_nxt_s;
    end
  end

  // Coin sequencing: coin activity is ignored until a debounced release.
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    coin_nxt_s  = btn_coin;
    count_nxt_s = coin_count;
    case (state_r)
      IDLE: begin
        if (deb_s[JOY_COIN]) begin
          state_nxt_s = PULSE;
          coin_nxt_s  = 1'b1;
          t_nxt_s     = T_ZERO;
          count_nxt_s = coin_count + 8'd1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PULSE: begin
        if (t_r == T_PULSE_LAST) begin
          state_nxt_s = GAP;
          coin_nxt_s  = 1'b0;
          t_nxt_s     = T_ZERO;
        end else begin
          t_nxt_s = t_r + T_ONE;
        end
      end
      GAP: begin
        if (t_r == T_GAP_LAST) begin
          state_nxt_s = WAIT_REL;
          t_nxt_s     = T_ZERO;
        end else begin
          t_nxt_s = t_r + T_ONE;
        end
      end
      WAIT_REL: begin
        if (!deb_s[JOY_COIN]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_REL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        t_nxt_s     = T_ZERO;
        coin_nxt_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Scoreboard bench for arcade_input_cond: a behavioural model predicts every
// output cycle, expectations are queued at drive time and popped at sampling.
module tb_arcade_input_cond;

  localparam int DEB_CYCLES = 4;
  localparam int COIN_PULSE = 8;
  localparam int COIN_GAP   = 6;
  localparam int CNT_W      = 17;
  localparam int SB_DEPTH   = 4;

  logic        clk;
  logic        reset;
  logic [15:0] joy_in;
  logic        btn_right, btn_left, btn_fire, btn_barrier, btn_coin;
  logic [1:0]  btn_player_start;
  logic [7:0]  coin_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  logic coin_prev = 1'b0;

  logic [14:0] sb_q [$];

  // model state
  logic [8:0] h0, h1, h2, h3;
  logic [8:0] dm;
  int         ph, n;
  logic       mcoin;
  logic [7:0] mcnt;

  arcade_input_cond #(
    .DEB_CYCLES(DEB_CYCLES),
    .COIN_PULSE(COIN_PULSE),
    .COIN_GAP  (COIN_GAP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .joy_in          (joy_in),
    .btn_right       (btn_right),
    .btn_left        (btn_left),
    .btn_fire        (btn_fire),
    .btn_barrier     (btn_barrier),
    .btn_player_start(btn_player_start),
    .btn_coin        (btn_coin),
    .coin_count      (coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] outs_vec();
    return {coin_count, btn_coin, btn_player_start, btn_barrier, btn_fire, btn_left, btn_right};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    h0 = 9'd0; h1 = 9'd0; h2 = 9'd0; h3 = 9'd0;
    dm = 9'd0; ph = 0; n = 0; mcoin = 1'b0; mcnt = 8'd0;
  endtask

  // One input sample; predicts the outputs four edges later.
  task automatic model_step(input logic [15:0] v);
    logic [8:0] all1, all0;
    h3 = h2; h2 = h1; h1 = h0; h0 = v[8:0];
    all1 = h0 & h1 & h2 & h3;
    all0 = ~(h0 | h1 | h2 | h3);
    dm = (dm | all1) & ~all0;
    case (ph)
      0: if (dm[8]) begin ph = 1; n = 0; mcoin = 1'b1; mcnt = mcnt + 8'd1; end
      1: begin n++; if (n == COIN_PULSE) begin ph = 2; n = 0; mcoin = 1'b0; end end
      2: begin n++; if (n == COIN_GAP) begin ph = 3; n = 0; end end
      default: if (!dm[8]) ph = 0;
    endcase
    sb_q.push_back({mcnt, mcoin, dm[7], dm[6], dm[5], dm[4],
                    dm[1] & ~dm[0], dm[0] & ~dm[1]});
  endtask

  task automatic step(input logic [15:0] v);
    @(posedge clk);
    #1;
    joy_in = v;
    model_step(v);
  endtask

  task automatic run(input logic [15:0] v, input int cycles);
    repeat (cycles) step(v);
  endtask

  // Mid-cycle reset: outputs must clear without a clock edge.
  task automatic do_reset(input logic [15:0] rel);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    joy_in = 16'h0000;
    #1;
    check_eq("reset_outs", {17'd0, outs_vec()}, 32'd0);
    sb_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    joy_in = rel;
    model_step(rel);
  endtask

  // Scoreboard compare plus coin rising-edge monitor.
  always @(negedge clk) begin
    if (!reset && sb_q.size() > SB_DEPTH) begin
      check_eq("sb_outs", {17'd0, outs_vec()}, {17'd0, sb_q.pop_front()});
    end
    if (btn_coin && !coin_prev) pulses++;
    coin_prev = btn_coin;
  end

  initial begin
    int p0;
    reset  = 1'b1;
    joy_in = 16'h0000;
    model_clear();
    repeat (3) @(posedge clk);

    // fire latency and hold
    do_reset(16'h0000);
    run(16'h0000, 2);
    run(16'h0010, 20);
    run(16'h0000, 12);

    // glitch rejection then minimum accepted pulse
    run(16'h0020, 3);
    run(16'h0000, 10);
    run(16'h0020, 4);
    run(16'h0000, 12);

    // left/right conflict, then left alone
    run(16'h0003, 20);
    run(16'h0002, 20);
    run(16'h0000, 12);

    // start1+start2+coin together, upper bits ignored
    run(16'hFFC0 & 16'hFFC0, 30);
    run(16'hFE00, 30);

    // coin held long: exactly one pulse
    do_reset(16'h0000);
    p0 = pulses;
    run(16'h0100, 100);
    run(16'h0000, 20);
    check_eq("hold_pulses", pulses - p0, 32'd1);
    check_eq("hold_count", {24'd0, coin_count}, 32'd1);

    // re-press overlapping the gap: still one pulse
    p0 = pulses;
    run(16'h0100, 10);
    run(16'h0000, 4);
    run(16'h0100, 8);
    run(16'h0000, 20);
    check_eq("gap_pulses", pulses - p0, 32'd1);

    // 256 insertions wrap the counter
    do_reset(16'h0000);
    p0 = pulses;
    repeat (256) begin
      run(16'h0100, 20);
      run(16'h0000, 20);
    end
    check_eq("wrap_pulses", pulses - p0, 32'd256);
    check_eq("wrap_count", {24'd0, coin_count}, 32'd0);

    // reset while pulse is high, released with coin still held
    do_reset(16'h0000);
    run(16'h0100, 10);
    check_eq("pre_rst_coin", {31'd0, btn_coin}, 32'd1);
    do_reset(16'h0100);
    run(16'h0100, 12);
    check_eq("post_rst_count", {24'd0, coin_count}, 32'd1);
    run(16'h0000, 20);

    run(16'h0000, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Conditions the merged player-control word before it reaches the Phoenix/Pleiads game core.
- Input is the OR of the USB and DB9/DB15 joystick words; outputs drive the core's btn_* inputs directly.
- Per-button functions: 2-flop synchronisation and debounce; left+right conflict cancellation; one fixed-width coin pulse per physical insertion; coin event counter for the OSD/debug.

Parameters:
- DEB_CYCLES, 11000, consecutive stable clk cycles before a debounced bit changes (1 ms at 11 MHz); must be >= 2.
- COIN_PULSE, 110000, width of btn_coin high pulse in clk cycles; must be >= 1.
- COIN_GAP, 110000, forced-low gap after each pulse in clk cycles; must be >= 1.
- CNT_W, 17, width of the debounce and coin timers; must hold max(DEB_CYCLES, COIN_PULSE, COIN_GAP).

Ports:
- clk, in, 1, system clock (clk_sys domain).
- reset, in, 1, asynchronous, active-high.
- joy_in, in, 16, raw word: [0]R [1]L [2]D [3]U [4]fire [5]barrier [6]start1 [7]start2 [8]coin; [15:9] ignored.
- btn_right, out, 1, conditioned right.
- btn_left, out, 1, conditioned left.
- btn_fire, out, 1, conditioned fire.
- btn_barrier, out, 1, conditioned barrier.
- btn_player_start, out, 2, {start2, start1}.
- btn_coin, out, 1, shaped coin pulse.
- coin_count, out, 8, number of coin pulses issued; wraps at 255 -> 0.

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all outputs, sync flops, debounce state, timers and FSM state are 0 (FSM in IDLE). Release needs no special sequencing.
- Synchronisation: each of bits [8:0] passes through 2 flops, giving s[i].
- Debounce, per bit and independent:
  - Hold register d[i] and counter c[i].
  - If s[i]==d[i]: c[i]<=0.
  - Else if c[i]==DEB_CYCLES-1: d[i]<=s[i] and c[i]<=0.
  - Else: c[i]<=c[i]+1.
  - Any glitch shorter than DEB_CYCLES cycles restarts the count and never reaches d.
- Output register, 1 cycle:
  - btn_right<=d[0]&~d[1]; btn_left<=d[1]&~d[0].
  - btn_fire<=d[4]; btn_barrier<=d[5]; btn_player_start<={d[7],d[6]}.
  - d[2], d[3] are debounced but unused at the outputs.
- Latency: a clean input edge appears on the outputs exactly DEB_CYCLES+3 clk edges later. Release latency is the same.
- Coin FSM, driven by d[8] and a single shared timer t:
  - IDLE: on d[8]==1, go to PULSE; set btn_coin<=1, t<=0, coin_count<=coin_count+1.
  - PULSE: t increments. When t==COIN_PULSE-1, go to GAP; set btn_coin<=0, t<=0.
  - GAP: t increments. When t==COIN_GAP-1, go to WAIT_REL.
  - WAIT_REL: when d[8]==0, go to IDLE. If d[8] is already 0 on entry, the exit happens on the next edge.
- Coin boundary rules:
  - Holding coin of any length gives exactly one pulse.
  - Coin activity during PULSE or GAP is ignored.
  - A second insertion needs a debounced release and re-press.
  - btn_coin rises at the same latency as the other buttons (DEB_CYCLES+3).
- Simultaneous events: left and right debounced together make both outputs 0. Coin with start in the same cycle: both are passed, with no priority.
- Reset mid-pulse: btn_coin drops immediately and coin_count clears to 0. After release a still-held coin counts as a new insertion once debounced.

Decomposition:
- Package arcade_input_pkg:
  - Bit-index localparams JOY_R=0, JOY_L=1, JOY_D=2, JOY_U=3, JOY_FIRE=4, JOY_BARRIER=5, JOY_START1=6, JOY_START2=7, JOY_COIN=8.
  - Enum coin_state_t {IDLE, PULSE, GAP, WAIT_REL}.
- Sub-module input_debounce: one bit, parameters DEB_CYCLES and CNT_W, ports clk, reset, din, dout. It contains the 2-flop sync and the counter, and is instantiated 9 times.
- The coin FSM and output register live in the top module.

Test Plan (all scenarios use DEB_CYCLES=4, COIN_PULSE=8, COIN_GAP=6):
- Reset and latency: assert reset, then step joy_in[4] 0->1 at edge 0. btn_fire rises at edge 7 and stays high. Asserting reset at any cycle forces all outputs to 0 in the same cycle, without a clock edge.
- Glitch reject: a 3-cycle pulse on joy_in[5] leaves btn_barrier 0 throughout. A 4-cycle pulse gives a btn_barrier pulse of 4 cycles, delayed 7.
- Left/right conflict: hold joy_in[1:0]=2'b11 for 20 cycles; btn_left=btn_right=0 throughout. Drop bit 0; btn_left=1 seven cycles later.
- Coin hold: hold joy_in[8] for 100 cycles. Expect exactly one btn_coin pulse of 8 cycles starting at edge 7, and coin_count 0->1.
- Coin repeat and wrap: 256 clean insertions, each press 20 cycles and release 20 cycles. Expect 256 pulses separated by at least 6 low cycles, with coin_count ending at 0. A press during GAP produces no extra pulse.
- Reset mid-pulse: assert reset 3 cycles into PULSE. btn_coin and coin_count go to 0 immediately. Release reset with coin held; a new pulse appears 7 edges later and coin_count=1.
